// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and helpers for the multiply/divide unit
package mdu_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step (
  input  logic [31:0] rem,
  input  logic        bit_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem, bit_in};
  assign diff    = shifted - {1'b0, divisor};

  // rem < divisor is invariant, so a clear borrow bit means shifted >= divisor
  assign q_bit    = ~diff[32];
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
module mdu #(
  parameter int ITER = mdu_pkg::ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] count_q;
  mdu_op_e       op_q;
  logic          neg_lo_q, neg_hi_q, div_zero_q;
  logic [31:0]   hi_acc, lo_acc, opnd;

  logic          accept;
  logic          in_signed, in_div, q_div;
  logic [31:0]   abs_a, abs_b;
  logic [32:0]   mul_sum;
  logic [31:0]   rem_next;
  logic          q_bit;
  logic [63:0]   prod_fix;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign in_signed = (mdu_op_e'(op) == OP_MULT) || (mdu_op_e'(op) == OP_DIV);
  assign in_div    = (mdu_op_e'(op) == OP_DIV) || (mdu_op_e'(op) == OP_DIVU);
  assign q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign abs_a     = abs32(a, in_signed);
  assign abs_b     = abs32(b, in_signed);

  // Multiply: hi_acc holds the running partial product, lo_acc the multiplier shifting out
  assign mul_sum  = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : 33'd0);
  assign prod_fix = neg_lo_q ? (~{hi_acc, lo_acc} + 64'd1) : {hi_acc, lo_acc};

  // Divide: hi_acc is the partial remainder, lo_acc shifts dividend out and quotient in
  mdu_div_step u_div_step (
    .rem      (hi_acc),
    .bit_in   (lo_acc[31]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_q       <= OP_MULT;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_acc     <= '0;
      lo_acc     <= '0;
      opnd       <= '0;
      hi_out     <= '0;
      lo_out     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q    <= '0;
        op_q       <= mdu_op_e'(op);
        neg_lo_q   <= in_signed && (a[31] ^ b[31]);
        neg_hi_q   <= in_signed && in_div && a[31];
        div_zero_q <= in_div && (b == 32'd0);
        hi_acc     <= '0;
        lo_acc     <= in_div ? abs_a : abs_b;
        opnd       <= in_div ? abs_b : abs_a;
      end else if (state_q == CALC) begin
        count_q <= count_q + CW'(1);
        if (q_div) begin
          hi_acc <= rem_next;
          lo_acc <= {lo_acc[30:0], q_bit};
        end else begin
          {hi_acc, lo_acc} <= {mul_sum, lo_acc[31:1]};
        end
      end else if (state_q == FIX) begin
        if (q_div) begin
          // a zero divisor leaves |a| as remainder; the dividend sign restores a itself
          lo_out <= div_zero_q ? 32'hFFFF_FFFF : (neg_lo_q ? neg32(lo_acc) : lo_acc);
          hi_out <= neg_hi_q ? neg32(hi_acc) : hi_acc;
        end else begin
          hi_out <= prod_fix[63:32];
          lo_out <= prod_fix[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for mdu against an arithmetic reference model
module tb_mdu;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  mdu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    h = '0;
    l = '0;
    case (o)
      MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {h, l} = sp;
      end
      MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        {h, l} = up;
      end
      default: begin
        if (y == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = x;
        end else if (o == DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else if (o == DIV) begin
          sq = $signed(x) / $signed(y);
          sr = $signed(x) % $signed(y);
          l = sq;
          h = sr;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called right after a negedge; start is sampled on the next posedge
  task automatic issue_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    e.hi  = h;
    e.lo  = l;
    e.cyc = cyc + 33;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] h, l;
    model(o, x, y, h, l);
    issue_exp(o, x, y, h, l);
  endtask

  // Monitor: pops the scoreboard on every done, checks result hold and busy length
  initial begin : monitor
    exp_t        e;
    int          run;
    logic [31:0] last_hi, last_lo;
    run = 0;
    last_hi = '0;
    last_lo = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        last_hi = '0;
        last_lo = '0;
      end else begin
        if (busy) begin
          run++;
          chk("hold_hi", hi_out, last_hi);
          chk("hold_lo", lo_out, last_lo);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("hi", hi_out, e.hi);
            chk("lo", lo_out, e.lo);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy_len", 64'(run), 64'd33);
          end
          last_hi = hi_out;
          last_lo = lo_out;
          run = 0;
        end
      end
    end
  end

  initial begin : driver
    int dcount;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    rst = 1'b0;
    @(negedge clk);

    issue_exp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    repeat (35) @(negedge clk);
    issue_exp(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    repeat (35) @(negedge clk);
    issue_exp(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    repeat (35) @(negedge clk);
    issue_exp(DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    repeat (35) @(negedge clk);
    issue_exp(DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    repeat (35) @(negedge clk);
    issue_exp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    repeat (35) @(negedge clk);
    issue(DIV, 32'hFFFF_FF00, 32'd0);
    repeat (35) @(negedge clk);

    // start during CALC must be ignored along with its operands
    issue(MULT, 32'h0001_2345, 32'hFFFF_FF10);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    a     = 32'd99;
    b     = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(negedge clk);

    // back-to-back: start held in the DONE cycle
    issue(DIV, 32'hFFFF_0000, 32'd17);
    repeat (34) @(negedge clk);
    issue(MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (35) @(negedge clk);

    // reset mid-operation aborts without a done pulse
    issue(MULTU, 32'h0000_1234, 32'h0000_5678);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    issue(DIVU, 32'd1000, 32'd7);
    repeat (35) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 3) == 0) repeat (34) @(negedge clk);
      else repeat (35 + $urandom_range(0, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request a new operation; sampled on the clk rising edge
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  multiplicand or dividend
- b  in  32  multiplier or divisor
- busy  out  1  an operation is in progress
- done  out  1  one-cycle pulse when the result is valid
- hi_out  out  32  MULT: product[63:32]; DIV: remainder
- lo_out  out  32  MULT: product[31:0]; DIV: quotient
REQ-003 The parameter SHALL be: ITER, default 32, number of iteration cycles.

Function
REQ-004 The states SHALL be IDLE, CALC, FIX and DONE.
REQ-005 Start acceptance: in IDLE or DONE, start=1 on edge E0 SHALL latch op, |a| and |b| (absolute values for signed ops), and the result signs, and SHALL enter CALC with count=0.
REQ-006 CALC SHALL perform one radix-2 step per edge: shift-add for MULT/MULTU, restoring subtract-shift for DIV/DIVU.
REQ-007 After ITER steps (edge E0+ITER), CALC SHALL go to FIX.
REQ-008 FIX SHALL apply sign correction and register hi_out and lo_out at edge E0+ITER+1, then go to DONE.
REQ-009 done SHALL be 1 only in DONE (exactly one cycle): 33 cycles after the start edge with ITER=32.
REQ-010 DONE SHALL go to IDLE on the next edge unless start=1, in which case REQ-005 applies (back-to-back operation).
REQ-011 busy SHALL be 1 exactly in CALC and FIX.
REQ-012 start SHALL be ignored while busy=1; a, b and op SHALL NOT be sampled in that case.
REQ-013 Multiply results SHALL be the full 64-bit product: two's complement for MULT, unsigned for MULTU.
REQ-014 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-015 DIV with 0x80000000 / 0xFFFFFFFF SHALL return lo=0x80000000, hi=0.
REQ-016 Divide by zero (b=0, DIV or DIVU) SHALL return lo=0xFFFFFFFF and hi=a, with normal latency and no error flag.
REQ-017 hi_out and lo_out SHALL hold the last result until the next FIX edge. They SHALL NOT change during CALC.
REQ-018 done is the write enable for the downstream HI/LO register, which writes on the falling clk edge.
REQ-019 hi_out and lo_out SHALL therefore be stable for the whole DONE cycle.

Reset
REQ-020 When rst=1, the module SHALL go asynchronously to IDLE.
REQ-021 Reset SHALL set busy=0, done=0, hi_out=0, lo_out=0, clear count and clear the internal accumulators.
REQ-022 If rst is asserted mid-operation, the operation SHALL be aborted and done SHALL NOT be pulsed.
REQ-023 The first start after rst deasserts SHALL be handled normally.

Structure
REQ-024 A shared package SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encoding, and the constant ITER=32.
REQ-025 One sub-module, mdu_div_step, SHALL be used: a combinational single restoring-division step (partial remainder, divisor -> next remainder, quotient bit).
REQ-026 The multiply datapath SHALL stay inline.
REQ-027 No `*` or `/` operators SHALL appear in the RTL.

Verification
REQ-028 MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for 32+1 cycles.
REQ-029 MULT, a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, a=7, b=2 -> lo=3, hi=1.
REQ-031 Boundary cases:
- DIVU b=0, a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 Start pulsed at cycle 10 of CALC with different operands -> ignored; the result matches the first operands.
REQ-033 Start held high in the DONE cycle -> the second operation completes 33 cycles later.
REQ-034 rst pulsed at cycle 15 of CALC -> immediate IDLE, busy=0, outputs 0, and no done pulse in the following 40 cycles.
